// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn scheduler: alternates AI (X) and human (O) moves,
// validates and commits them, judges the board and keeps the session score.
module turn_sequencer #(
    parameter int AI_TIMEOUT = 255,
    parameter int SCORE_W    = 8,
    parameter bit AI_FIRST   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               move,
    input  logic [3:0]         tile,
    input  logic               ai_hard_sel,
    input  logic [8:0]         ai_easy_move,
    input  logic [8:0]         ai_hard_move,
    input  logic               ai_done,
    input  logic [8:0]         x_board,
    input  logic [8:0]         o_board,
    output logic               ai_start,
    output logic [8:0]         commit_x,
    output logic [8:0]         commit_o,
    output logic               commit_valid,
    output logic               clear_board,
    output logic               turn,
    output logic [2:0]         status,
    output logic               ai_fault,
    output logic [SCORE_W-1:0] x_wins,
    output logic [SCORE_W-1:0] o_wins,
    output logic [SCORE_W-1:0] draws
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, X_REQ, AI_WAIT, X_COMMIT,
        O_WAIT, O_COMMIT, CHECK, GAME_OVER
    } state_t;

    localparam int TW = $clog2(AI_TIMEOUT + 1);

    localparam logic [8:0] LINES [8] = '{
        9'h1C0, 9'h038, 9'h007,
        9'h124, 9'h092, 9'h049,
        9'h111, 9'h054
    };

    state_t state, next;

    logic [TW-1:0] tcnt;
    logic [8:0]    pick;
    logic          fault_q;
    logic          bad_q;
    logic [1:0]    result;

    logic [8:0] occ, ai_mv, fallback, o_mv, plane;
    logic       ai_legal, o_legal, timed_out, win, full;

    assign occ       = x_board | o_board;
    assign ai_mv     = ai_hard_sel ? ai_hard_move : ai_easy_move;
    assign ai_legal  = $onehot(ai_mv) && ((ai_mv & occ) == 9'h000);
    assign timed_out = !ai_done && (tcnt == TW'(AI_TIMEOUT - 1));
    assign o_mv      = 9'h100 >> tile;
    assign o_legal   = (tile <= 4'd8) && ((o_mv & occ) == 9'h000);
    assign plane     = turn ? x_board : o_board;
    assign full      = &occ;

    // Upward scan so the last hit is the highest bit, i.e. the lowest tile
    always_comb begin
        fallback = 9'h000;
        for (int i = 0; i < 9; i++)
            if (!occ[i]) fallback = 9'h001 << i;
    end

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++)
            if ((plane & LINES[i]) == LINES[i]) win = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      if (new_game) next = CLEAR;
            CLEAR:     next = turn ? X_REQ : O_WAIT;
            X_REQ:     next = AI_WAIT;
            AI_WAIT:   if (ai_done || timed_out) next = X_COMMIT;
            X_COMMIT:  next = CHECK;
            O_WAIT:    if (move && o_legal) next = O_COMMIT;
            O_COMMIT:  next = CHECK;
            CHECK: begin
                if (win || full) next = GAME_OVER;
                else             next = turn ? O_WAIT : X_REQ;
            end
            GAME_OVER: if (new_game) next = CLEAR;
            default:   next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt    <= '0;
            pick    <= '0;
            fault_q <= 1'b0;
            bad_q   <= 1'b0;
            turn    <= AI_FIRST;
            result  <= '0;
            x_wins  <= '0;
            o_wins  <= '0;
            draws   <= '0;
        end else begin
            bad_q <= (state == O_WAIT) && move && !o_legal;
            if (state == X_REQ)
                tcnt <= '0;
            else if (state == AI_WAIT && !ai_done && !timed_out)
                tcnt <= tcnt + 1'b1;
            if (state == AI_WAIT) begin
                fault_q <= !(ai_done && ai_legal);
                pick    <= (ai_done && ai_legal) ? ai_mv : fallback;
            end
            if (state == O_WAIT)
                pick <= o_mv;
            if ((state == IDLE || state == GAME_OVER) && new_game)
                turn <= AI_FIRST;
            if (state == CHECK) begin
                if (win) begin
                    result <= turn ? 2'd1 : 2'd2;
                    if (turn && x_wins != '1)  x_wins <= x_wins + 1'b1;
                    if (!turn && o_wins != '1) o_wins <= o_wins + 1'b1;
                end else if (full) begin
                    result <= 2'd3;
                    if (draws != '1) draws <= draws + 1'b1;
                end else begin
                    turn <= !turn;
                end
            end
        end
    end

    always_comb begin
        ai_start     = (state == X_REQ);
        clear_board  = (state == CLEAR);
        commit_valid = (state == X_COMMIT) || (state == O_COMMIT);
        commit_x     = (state == X_COMMIT) ? pick : 9'h000;
        commit_o     = (state == O_COMMIT) ? pick : 9'h000;
        ai_fault     = (state == X_COMMIT) && fault_q;
        case (state)
            O_WAIT:    status = bad_q ? 3'd4 : 3'd7;
            O_COMMIT:  status = 3'd7;
            CHECK:     status = turn ? 3'd0 : 3'd7;
            GAME_OVER: status = {1'b0, result};
            default:   status = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized self-checking bench for turn_sequencer against a tile-array
// model of the game; the bench also plays the role of the board datapath.
module tb_turn_sequencer;

    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst, new_game, move, ai_hard_sel, ai_done;
    logic [3:0] tile;
    logic [8:0] ai_easy_move, ai_hard_move, x_board, o_board;
    logic       ai_start, commit_valid, clear_board, turn, ai_fault;
    logic [8:0] commit_x, commit_o;
    logic [2:0] status;
    logic [7:0] x_wins, o_wins, draws;

    int checks = 0;
    int errors = 0;
    int own [9];
    bit mturn, over;
    int ex_x, ex_o, ex_d, ex_st;

    always #5 clk = ~clk;

    turn_sequencer #(.AI_TIMEOUT(TO), .SCORE_W(8), .AI_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .move(move), .tile(tile),
        .ai_hard_sel(ai_hard_sel), .ai_easy_move(ai_easy_move),
        .ai_hard_move(ai_hard_move), .ai_done(ai_done),
        .x_board(x_board), .o_board(o_board), .ai_start(ai_start),
        .commit_x(commit_x), .commit_o(commit_o),
        .commit_valid(commit_valid), .clear_board(clear_board),
        .turn(turn), .status(status), .ai_fault(ai_fault),
        .x_wins(x_wins), .o_wins(o_wins), .draws(draws)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] bit_of(input int t);
        logic [8:0] m;
        m = 9'h000;
        m[8-t] = 1'b1;
        return m;
    endfunction

    task automatic sync_board;
        x_board = 9'h000;
        o_board = 9'h000;
        for (int t = 0; t < 9; t++) begin
            if (own[t] == 1) x_board = x_board | bit_of(t);
            if (own[t] == 2) o_board = o_board | bit_of(t);
        end
    endtask

    function automatic bit three(input int a, input int b, input int c,
                                 input int p);
        return own[a] == p && own[b] == p && own[c] == p;
    endfunction

    function automatic bit has_line(input int p);
        for (int r = 0; r < 3; r++)
            if (three(3*r, 3*r+1, 3*r+2, p)) return 1'b1;
        for (int c = 0; c < 3; c++)
            if (three(c, c+3, c+6, p)) return 1'b1;
        return three(0, 4, 8, p) || three(2, 4, 6, p);
    endfunction

    function automatic bit is_full;
        for (int t = 0; t < 9; t++)
            if (own[t] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int lowest_free;
        for (int t = 0; t < 9; t++)
            if (own[t] == 0) return t;
        return -1;
    endfunction

    // random tile owned by `who`, -1 if there is none
    function automatic int rand_tile(input int who);
        int list [$];
        for (int t = 0; t < 9; t++)
            if (own[t] == who) list.push_back(t);
        if (list.size() == 0) return -1;
        return list[$urandom_range(0, list.size() - 1)];
    endfunction

    task automatic check_score;
        chk("x_wins", 32'(x_wins), 32'(ex_x));
        chk("o_wins", 32'(o_wins), 32'(ex_o));
        chk("draws", 32'(draws), 32'(ex_d));
    endtask

    task automatic post_commit(input int p);
        step;
        chk("cv_drop", 32'(commit_valid), 32'd0);
        step;
        if (has_line(p)) begin
            over = 1'b1;
            ex_st = (p == 1) ? 1 : 2;
            if (p == 1) ex_x++;
            else        ex_o++;
        end else if (is_full()) begin
            over = 1'b1;
            ex_st = 3;
            ex_d++;
        end else begin
            mturn = !mturn;
            chk("turn", 32'(turn), 32'(mturn));
            chk("next_st", 32'(status), mturn ? 32'd0 : 32'd7);
        end
        if (over) begin
            chk("end_st", 32'(status), 32'(ex_st));
            check_score();
            step;
            chk("hold_st", 32'(status), 32'(ex_st));
            check_score();
        end
    endtask

    task automatic start_game;
        new_game = 1'b1;
        step;
        new_game = 1'b0;
        chk("clear", 32'(clear_board), 32'd1);
        for (int t = 0; t < 9; t++) own[t] = 0;
        sync_board();
        mturn = 1'b1;
        over  = 1'b0;
        step;
        chk("start", 32'(ai_start), 32'd1);
        chk("start_st", 32'(status), 32'd0);
    endtask

    task automatic ai_turn(input logic [8:0] mv, input bit hard,
                           input bit tmo, input bit noise);
        int  n, tgt;
        bit  legal;
        n = 0;
        while (!ai_start && n < 20) begin
            step;
            n++;
        end
        chk("ai_start", 32'(ai_start), 32'd1);
        ai_hard_sel = hard;
        if (hard) begin
            ai_hard_move = mv;
            ai_easy_move = 9'($urandom);
        end else begin
            ai_easy_move = mv;
            ai_hard_move = 9'($urandom);
        end
        legal = !tmo && ($countones(mv) == 1);
        tgt = 0;
        if (legal) begin
            for (int t = 0; t < 9; t++)
                if (mv[8-t]) tgt = t;
            if (own[tgt] != 0) legal = 1'b0;
        end
        if (!legal) tgt = lowest_free();
        ai_done = !tmo;
        if (noise) begin
            move     = 1'b1;
            tile     = 4'($urandom_range(0, 8));
            new_game = 1'b1;
        end
        n = 0;
        do begin
            step;
            n++;
            if (n == 1 && noise)
                chk("noise_clr", 32'(clear_board), 32'd0);
            move     = 1'b0;
            new_game = 1'b0;
        end while (!commit_valid && n < TO + 40);
        chk("ai_lat", 32'(n), tmo ? 32'(TO + 1) : 32'd2);
        chk("cx", 32'(commit_x), 32'(bit_of(tgt)));
        chk("co_x", 32'(commit_o), 32'd0);
        chk("fault", 32'(ai_fault), 32'(!legal));
        ai_done = 1'b0;
        own[tgt] = 1;
        sync_board();
        post_commit(1);
    endtask

    task automatic human(input int t);
        bit ok;
        ok = 1'b0;
        if (t >= 0 && t <= 8) ok = (own[t] == 0);
        chk("o_wait", 32'(status), 32'd7);
        move = 1'b1;
        tile = 4'(t);
        step;
        move = 1'b0;
        if (!ok) begin
            chk("bad_st", 32'(status), 32'd4);
            chk("bad_cv", 32'(commit_valid), 32'd0);
            step;
            chk("bad_back", 32'(status), 32'd7);
        end else begin
            chk("o_cv", 32'(commit_valid), 32'd1);
            chk("co", 32'(commit_o), 32'(bit_of(t)));
            chk("cx_o", 32'(commit_x), 32'd0);
            own[t] = 2;
            sync_board();
            post_commit(2);
        end
    endtask

    task automatic random_game;
        int g, k, t;
        logic [8:0] mv;
        start_game();
        g = 0;
        while (!over && g < 30) begin
            g++;
            if (mturn) begin
                k = $urandom_range(0, 19);
                t = rand_tile(0);
                if (k <= 2 && rand_tile(1) >= 0) mv = bit_of(rand_tile(1));
                else if (k == 3)                 mv = bit_of(t) | 9'h001;
                else if (k == 4)                 mv = 9'h000;
                else                             mv = bit_of(t);
                ai_turn(mv, 1'($urandom), k == 19, k == 5);
            end else begin
                k = $urandom_range(0, 5);
                if (k == 0)                        t = $urandom_range(9, 15);
                else if (k == 1 && rand_tile(1) >= 0) t = rand_tile(1);
                else                               t = rand_tile(0);
                human(t);
            end
        end
        chk("game_end", 32'(over), 32'd1);
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; move = 1'b0; tile = 4'd0;
        ai_hard_sel = 1'b0; ai_done = 1'b0;
        ai_easy_move = 9'h000; ai_hard_move = 9'h000;
        ex_x = 0; ex_o = 0; ex_d = 0; ex_st = 0;
        for (int t = 0; t < 9; t++) own[t] = 0;
        sync_board();
        step;
        step;
        rst = 1'b0;
        step;
        chk("rst_st", 32'(status), 32'd0);
        chk("rst_turn", 32'(turn), 32'd1);
        chk("rst_cv", 32'(commit_valid), 32'd0);
        chk("rst_clr", 32'(clear_board), 32'd0);
        chk("rst_start", 32'(ai_start), 32'd0);
        check_score();

        // game 1: invalid human moves, ignored new_game, AI timeout, O wins
        start_game();
        ai_turn(9'h100, 1'b0, 1'b0, 1'b0);
        human(0);
        human(9);
        new_game = 1'b1;
        step;
        new_game = 1'b0;
        chk("ng_ignored", 32'(clear_board), 32'd0);
        chk("ng_st", 32'(status), 32'd7);
        human(1);
        ai_turn(9'h000, 1'b0, 1'b1, 1'b0);
        human(4);
        ai_turn(bit_of(3), 1'b1, 1'b0, 1'b0);
        human(7);

        // game 2: X wins on the main diagonal
        start_game();
        ai_turn(bit_of(0), 1'b1, 1'b0, 1'b0);
        human(1);
        ai_turn(bit_of(4), 1'b0, 1'b0, 1'b1);
        human(2);
        ai_turn(bit_of(8), 1'b1, 1'b0, 1'b0);

        // game 3: draw
        start_game();
        ai_turn(bit_of(0), 1'b0, 1'b0, 1'b0);
        human(1);
        ai_turn(bit_of(2), 1'b0, 1'b0, 1'b0);
        human(4);
        ai_turn(bit_of(3), 1'b1, 1'b0, 1'b0);
        human(5);
        ai_turn(bit_of(7), 1'b0, 1'b0, 1'b0);
        human(6);
        ai_turn(bit_of(8), 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) random_game();

        // reset in the middle of a game
        start_game();
        ai_turn(bit_of(rand_tile(0)), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        ex_x = 0; ex_o = 0; ex_d = 0;
        chk("mid_rst_st", 32'(status), 32'd0);
        chk("mid_rst_turn", 32'(turn), 32'd1);
        chk("mid_rst_cv", 32'(commit_valid), 32'd0);
        check_score();
        start_game();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
